// File: rtl/multicycle_control_fsm_if.sv
// Unified-memory request handshake between the control FSM (master) and the memory (slave).
interface multicycle_control_fsm_if;
    logic mem_req;
    logic mem_we;
    logic mem_addr_sel;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output mem_addr_sel, input mem_ready);
    modport slave  (input mem_req, input mem_we, input mem_addr_sel, output mem_ready);
endinterface

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multi-cycle RV32I core: FETCH/DECODE/EXECUTE/MEM/WB sequencing.
// Optional `ILLEGAL_TRAP_EN: unknown opcodes fault instead of retiring as a NOP.
module multicycle_control_fsm #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int STATE_W      = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    multicycle_control_fsm_if.master mem,
    input  logic [31:0]              instr,
    input  logic                     branch_taken,
    output logic                     ir_we,
    output logic                     pc_we,
    output logic [1:0]               pc_src,
    output logic [1:0]               alu_a_sel,
    output logic [1:0]               alu_b_sel,
    output logic [1:0]               alu_op,
    output logic                     rf_we,
    output logic [1:0]               wb_sel,
    output logic [STATE_W-1:0]       state,
    output logic                     instr_retired,
    output logic                     halted,
    output logic                     fault
);

    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        EXECUTE = 3'd2,
        MEM     = 3'd3,
        WB      = 3'd4,
        HALT    = 3'd5,
        FAULT   = 3'd6
    } state_t;

    localparam logic [6:0] OP_R      = 7'd51;
    localparam logic [6:0] OP_IALU   = 7'd19;
    localparam logic [6:0] OP_LOAD   = 7'd3;
    localparam logic [6:0] OP_STORE  = 7'd35;
    localparam logic [6:0] OP_LUI    = 7'd55;
    localparam logic [6:0] OP_AUIPC  = 7'd23;
    localparam logic [6:0] OP_BRANCH = 7'd99;
    localparam logic [6:0] OP_JAL    = 7'd111;
    localparam logic [6:0] OP_JALR   = 7'd103;
    localparam logic [6:0] OP_SYSTEM = 7'd115;

    localparam logic [1:0] ALU_ADD  = 2'd0;
    localparam logic [1:0] ALU_FUNC = 2'd1;
    localparam logic [1:0] ALU_BR   = 2'd2;
    localparam logic [1:0] ALU_PASS = 2'd3;

    localparam int CNT_W = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);
    localparam logic [CNT_W:0] WAIT_LIMIT = (CNT_W+1)'(MEM_WAIT_MAX);

    state_t           state_q;
    logic [CNT_W-1:0] wait_cnt;
    logic [6:0]       op;
    logic             mem_phase;
    logic             stall;
    logic             timeout;
    logic [CNT_W:0]   cnt_inc;
    logic             unused_instr_bits;

    assign op                = instr[6:0];
    assign unused_instr_bits = &{1'b0, instr[31:7]};
    assign state             = STATE_W'(state_q);

    function automatic logic is_known(input logic [6:0] opc);
        case (opc)
            OP_R, OP_IALU, OP_LOAD, OP_STORE, OP_LUI, OP_AUIPC,
            OP_BRANCH, OP_JAL, OP_JALR, OP_SYSTEM: is_known = 1'b1;
            default:                                is_known = 1'b0;
        endcase
    endfunction

    // A stall is counted only while a request is actually outstanding.
    assign mem_phase = (state_q == FETCH) || (state_q == MEM);
    assign stall     = mem_phase && !mem.mem_ready;
    assign cnt_inc   = {1'b0, wait_cnt} + (CNT_W+1)'(1);
    assign timeout   = (MEM_WAIT_MAX != 0) && stall && (cnt_inc == WAIT_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FETCH;
            wait_cnt <= '0;
            halted   <= 1'b0;
            fault    <= 1'b0;
        end else begin
            wait_cnt <= (stall && !timeout) ? cnt_inc[CNT_W-1:0] : '0;
            case (state_q)
                FETCH: begin
                    if (mem.mem_ready) begin
                        state_q <= DECODE;
                    end else if (timeout) begin
                        state_q <= FAULT;
                        fault   <= 1'b1;
                    end
                end
                DECODE: begin
                    if (op == OP_SYSTEM) begin
                        state_q <= HALT;
                        halted  <= 1'b1;
                    end else if (!is_known(op)) begin
`ifdef ILLEGAL_TRAP_EN
                        state_q <= FAULT;
                        fault   <= 1'b1;
`else
                        state_q <= FETCH;
`endif
                    end else begin
                        state_q <= EXECUTE;
                    end
                end
                EXECUTE: begin
                    case (op)
                        OP_LOAD, OP_STORE: state_q <= MEM;
                        OP_BRANCH:         state_q <= FETCH;
                        default:           state_q <= WB;
                    endcase
                end
                MEM: begin
                    if (mem.mem_ready) begin
                        state_q <= (op == OP_STORE) ? FETCH : WB;
                    end else if (timeout) begin
                        state_q <= FAULT;
                        fault   <= 1'b1;
                    end
                end
                WB:          state_q <= FETCH;
                HALT, FAULT: state_q <= state_q;
                default:     state_q <= FETCH;
            endcase
        end
    end

    // Outputs are forced low while reset is held so an aborted instruction leaves no writes.
    always_comb begin
        mem.mem_req      = 1'b0;
        mem.mem_we       = 1'b0;
        mem.mem_addr_sel = 1'b0;
        ir_we            = 1'b0;
        pc_we            = 1'b0;
        pc_src           = 2'd0;
        alu_a_sel        = 2'd0;
        alu_b_sel        = 2'd0;
        alu_op           = ALU_ADD;
        rf_we            = 1'b0;
        wb_sel           = 2'd0;
        instr_retired    = 1'b0;
        if (rst_n) begin
            case (state_q)
                FETCH: begin
                    mem.mem_req = 1'b1;
                    alu_a_sel   = 2'd1;
                    alu_b_sel   = 2'd2;
                    if (mem.mem_ready) begin
                        ir_we = 1'b1;
                        pc_we = 1'b1;
                    end
                end
                DECODE: begin
`ifdef ILLEGAL_TRAP_EN
                    instr_retired = 1'b0;
`else
                    instr_retired = !is_known(op);
`endif
                end
                EXECUTE: begin
                    case (op)
                        OP_R:    alu_op = ALU_FUNC;
                        OP_IALU: begin alu_b_sel = 2'd1; alu_op = ALU_FUNC; end
                        OP_LOAD, OP_STORE: alu_b_sel = 2'd1;
                        OP_LUI:  begin alu_a_sel = 2'd3; alu_b_sel = 2'd1; alu_op = ALU_PASS; end
                        OP_AUIPC: begin alu_a_sel = 2'd2; alu_b_sel = 2'd1; end
                        OP_BRANCH: begin
                            alu_op        = ALU_BR;
                            pc_src        = 2'd1;
                            pc_we         = branch_taken;
                            instr_retired = 1'b1;
                        end
                        OP_JAL: begin
                            alu_a_sel = 2'd2;
                            alu_b_sel = 2'd1;
                            pc_we     = 1'b1;
                            pc_src    = 2'd1;
                        end
                        OP_JALR: begin
                            alu_b_sel = 2'd1;
                            pc_we     = 1'b1;
                            pc_src    = 2'd2;
                        end
                        default: ;
                    endcase
                end
                MEM: begin
                    mem.mem_req      = 1'b1;
                    mem.mem_addr_sel = 1'b1;
                    mem.mem_we       = (op == OP_STORE);
                    instr_retired    = mem.mem_ready && (op == OP_STORE);
                end
                WB: begin
                    rf_we         = 1'b1;
                    instr_retired = 1'b1;
                    if (op == OP_LOAD)                        wb_sel = 2'd1;
                    else if (op == OP_JAL || op == OP_JALR)   wb_sel = 2'd2;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench: per-instruction state-path model plus directed literal checks and random traffic.
module tb_multicycle_control_fsm;

    localparam int MAXW = 15;
`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       mem_addr_sel;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic [1:0] alu_a;
        logic [1:0] alu_b;
        logic [1:0] alu_op;
        logic       rf_we;
        logic [1:0] wb_sel;
        logic [2:0] state;
        logic       retired;
        logic       halted;
        logic       fault;
    } out_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = '0;
    logic        branch_taken = 1'b0;
    logic        ir_we, pc_we, rf_we, instr_retired, halted, fault;
    logic [1:0]  pc_src, alu_a_sel, alu_b_sel, alu_op, wb_sel;
    logic [2:0]  state;

    multicycle_control_fsm_if mem_bus();

    multicycle_control_fsm #(.MEM_WAIT_MAX(MAXW), .STATE_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .mem(mem_bus.master), .instr(instr),
        .branch_taken(branch_taken), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
        .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_op(alu_op), .rf_we(rf_we),
        .wb_sel(wb_sel), .state(state), .instr_retired(instr_retired),
        .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    out_t        hq[$];
    logic [31:0] instr_q[$];
    logic [31:0] cur_instr = '0;
    logic [2:0]  path[$];
    int          step, wcnt, burst;
    bit          m_halted, m_fault;
    logic        rdy;
    logic [6:0]  op_pool [16] = '{7'd51, 7'd19, 7'd3, 7'd35, 7'd55, 7'd23, 7'd99, 7'd111,
                                  7'd103, 7'd51, 7'd19, 7'd3, 7'd35, 7'd99, 7'h7F, 7'd115};

    function automatic bit known(input logic [6:0] op);
        case (op)
            7'd51, 7'd19, 7'd3, 7'd35, 7'd55, 7'd23, 7'd99, 7'd111, 7'd103, 7'd115: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // State sequence an instruction walks through, FETCH first.
    function automatic void load_path(input logic [6:0] op);
        path.delete();
        path.push_back(3'd0);
        path.push_back(3'd1);
        if (op == 7'd115) path.push_back(3'd5);
        else if (!known(op)) begin
            if (TRAP) path.push_back(3'd6);
        end else begin
            path.push_back(3'd2);
            if (op == 7'd3) begin path.push_back(3'd3); path.push_back(3'd4); end
            else if (op == 7'd35) path.push_back(3'd3);
            else if (op != 7'd99) path.push_back(3'd4);
        end
    endfunction

    function automatic logic [31:0] next_instr();
        if (instr_q.size() > 0) return instr_q.pop_front();
        return {$urandom_range(0, 32'h1FFFFFF), 7'd0} | {25'd0, op_pool[$urandom_range(0, 15)]};
    endfunction

    function automatic void model_reset();
        path.delete();
        path.push_back(3'd0);
        step = 0; wcnt = 0; m_halted = 0; m_fault = 0;
        instr_q.delete();
    endfunction

    function automatic void model_step(input logic r);
        logic [2:0] st;
        st = path[step];
        if (st == 3'd5 || st == 3'd6) return;
        if ((st == 3'd0 || st == 3'd3) && !r) begin
            wcnt++;
            if (MAXW != 0 && wcnt == MAXW) begin
                path.delete(); path.push_back(3'd6); step = 0; wcnt = 0; m_fault = 1;
            end
            return;
        end
        wcnt = 0;
        if (st == 3'd0) begin
            cur_instr = next_instr();
            load_path(cur_instr[6:0]);
            step = 1;
        end else begin
            step++;
            if (step >= path.size()) begin path.delete(); path.push_back(3'd0); step = 0; end
        end
        if (path[step] == 3'd5) m_halted = 1;
        if (path[step] == 3'd6) m_fault = 1;
    endfunction

    function automatic out_t model_out(input logic r, input logic tk);
        out_t o;
        logic [6:0] op;
        o = '0;
        op = cur_instr[6:0];
        o.state = path[step]; o.halted = m_halted; o.fault = m_fault;
        case (path[step])
            3'd0: begin o.mem_req = 1; o.alu_a = 1; o.alu_b = 2; o.ir_we = r; o.pc_we = r; end
            3'd1: o.retired = !TRAP && !known(op);
            3'd2: case (op)
                7'd51:  o.alu_op = 1;
                7'd19:  begin o.alu_b = 1; o.alu_op = 1; end
                7'd3, 7'd35: o.alu_b = 1;
                7'd55:  begin o.alu_a = 3; o.alu_b = 1; o.alu_op = 3; end
                7'd23:  begin o.alu_a = 2; o.alu_b = 1; end
                7'd99:  begin o.alu_op = 2; o.pc_src = 1; o.pc_we = tk; o.retired = 1; end
                7'd111: begin o.alu_a = 2; o.alu_b = 1; o.pc_we = 1; o.pc_src = 1; end
                7'd103: begin o.alu_b = 1; o.pc_we = 1; o.pc_src = 2; end
                default: ;
            endcase
            3'd3: begin
                o.mem_req = 1; o.mem_addr_sel = 1; o.mem_we = (op == 7'd35);
                o.retired = r && (op == 7'd35);
            end
            3'd4: begin
                o.rf_we = 1; o.retired = 1;
                o.wb_sel = (op == 7'd3) ? 2'd1 : ((op == 7'd111 || op == 7'd103) ? 2'd2 : 2'd0);
            end
            default: ;
        endcase
        return o;
    endfunction

    function automatic out_t dut_out();
        return {mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_addr_sel, ir_we, pc_we, pc_src,
                alu_a_sel, alu_b_sel, alu_op, rf_we, wb_sel, state, instr_retired, halted, fault};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic cycle(input logic r, input logic tk);
        out_t act, exp;
        mem_bus.mem_ready = r;
        branch_taken = tk;
        instr = cur_instr;
        #2;
        act = dut_out();
        exp = model_out(r, tk);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL cycle_compare t=%0t dut=%h model=%h", $time, act, exp);
        end
        hq.push_back(act);
        @(posedge clk);
        model_step(r);
        @(negedge clk);
    endtask

    task automatic run(input logic [31:0] ins, input int n, input logic [31:0] mask, input logic tk);
        hq.delete();
        instr_q.push_back(ins);
        for (int i = 0; i < n; i++) cycle(mask[i], tk);
    endtask

    task automatic reset_now();
        rst_n = 1'b0;
        mem_bus.mem_ready = 1'b0;
        #1;
        chk("reset_outputs", int'(dut_out()), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        mem_bus.mem_ready = 1'b0;
        burst = 0;
        model_reset();
        @(negedge clk);
        reset_now();

        run(32'h002081B3, 4, 32'hF, 1'b0);
        chk("add_states", {hq[0].state, hq[1].state, hq[2].state, hq[3].state}, 12'o0124);
        chk("add_rf_we", {hq[0].rf_we, hq[1].rf_we, hq[2].rf_we, hq[3].rf_we}, 4'b0001);
        chk("add_retired", hq[0].retired + hq[1].retired + hq[2].retired + hq[3].retired, 1);

        run(32'h0000A103, 5, 32'h1F, 1'b0);
        chk("lw_states", {hq[0].state, hq[1].state, hq[2].state, hq[3].state, hq[4].state}, 15'o01234);
        chk("lw_mem", {hq[3].mem_we, hq[3].mem_addr_sel}, 2'b01);
        chk("lw_wb_sel", hq[4].wb_sel, 1);

        run(32'h0020A023, 7, 32'h47, 1'b0);
        chk("sw_states", {hq[0].state, hq[1].state, hq[2].state, hq[3].state, hq[4].state,
                          hq[5].state, hq[6].state}, 21'o0123333);
        chk("sw_req_we", {hq[3].mem_req, hq[3].mem_we, hq[4].mem_req, hq[4].mem_we,
                          hq[5].mem_req, hq[5].mem_we, hq[6].mem_req, hq[6].mem_we}, 8'hFF);
        chk("sw_retire", {hq[0].retired, hq[1].retired, hq[2].retired, hq[3].retired,
                          hq[4].retired, hq[5].retired, hq[6].retired}, 7'b0000001);

        run(32'h00208463, 3, 32'h7, 1'b1);
        chk("beq_t_states", {hq[0].state, hq[1].state, hq[2].state}, 9'o012);
        chk("beq_t_pc", {hq[2].pc_we, hq[2].pc_src, hq[2].retired}, 4'b1011);
        run(32'h00208463, 3, 32'h7, 1'b0);
        chk("beq_nt_pc", {hq[2].state, hq[2].pc_we, hq[2].retired}, 5'b01001);
        chk("beq_nt_next", hq.size() == 3 ? int'(state) : -1, 0);

        run(32'h002081B3, 2, 32'h3, 1'b0);
        chk("pre_reset_in_exec", int'(state), 2);
        reset_now();
        run(32'h002081B3, 1, 32'h0, 1'b0);
        chk("post_reset_fetch", {hq[0].state, hq[0].mem_req}, 4'b0001);
        reset_now();

        run(32'h002081B3, 16, 32'h0, 1'b0);
        chk("timeout_pre", {hq[14].state, hq[14].mem_req, hq[14].fault}, 5'b00010);
        chk("timeout_fault", {hq[15].state, hq[15].fault, hq[15].mem_req}, 5'b11010);
        reset_now();

        run(32'h0000007F, 3, 32'h3, 1'b0);
        if (TRAP) begin
            chk("illegal_trap", {hq[2].state, hq[2].fault, hq[1].retired}, 5'b11010);
        end else begin
            chk("illegal_nop", {hq[1].retired, hq[2].state, hq[2].mem_req}, 5'b10001);
        end
        reset_now();

        run(32'h00000073, 5, 32'h1F, 1'b0);
        chk("ecall_halt", {hq[2].state, hq[2].halted}, 4'b1011);
        chk("ecall_sticky", {hq[4].state, hq[4].halted, hq[4].mem_req}, 5'b10110);
        reset_now();

        for (int i = 0; i < 4000; i++) begin
            if (m_halted || m_fault) begin
                reset_now();
            end else begin
                if (burst == 0 && $urandom_range(0, 299) == 0) burst = $urandom_range(10, 18);
                rdy = (burst > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
                if (burst > 0) burst--;
                cycle(rdy, 1'($urandom_range(0, 1)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
